// File: rtl/muldiv_unit_if.sv
// Request/response channel of the RV32M multiply/divide unit.
// Master drives operands, op and resp_ready; slave returns handshake, result and busy.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic [2:0]      op;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output req_valid, A, B, op, resp_ready,
    input  req_ready, resp_valid, result, busy
  );

  modport slave (
    input  req_valid, A, B, op, resp_ready,
    output req_ready, resp_valid, result, busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M mul/div (shift-add multiply, restoring divide); resp_valid XLEN+1 cycles after accept.
// Backpressure: result held in DONE until resp_ready; req_ready is high only in IDLE.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam int              CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_r;
  logic [XLEN-1:0]   a_raw, mag_a, mag_b, result_r;
  logic              a_neg, b_neg, b_zero, ovf;
  logic [2*XLEN-1:0] work;

  logic              sgn_a, sgn_b;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [XLEN:0]     add_sum, sub_shift, sub_diff;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fix_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = CALC;
      CALC:    if (cnt == CNT_LAST) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (bus.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.resp_valid = (state == DONE);
    bus.busy       = (state != IDLE);
  end

  assign bus.result = result_r;

  // Operand signedness by funct3; MUL is treated as signed since its low half is sign-agnostic.
  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    case (bus.op)
      3'd0, 3'd1, 3'd4, 3'd6: begin
        sgn_a = 1'b1;
        sgn_b = 1'b1;
      end
      3'd2:    sgn_a = 1'b1;
      default: ;
    endcase
    abs_a = (sgn_a && bus.A[XLEN-1]) ? (~bus.A + 1'b1) : bus.A;
    abs_b = (sgn_b && bus.B[XLEN-1]) ? (~bus.B + 1'b1) : bus.B;
  end

  // work holds {acc, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  always_comb begin
    add_sum   = {1'b0, work[2*XLEN-1:XLEN]} + (work[0] ? {1'b0, mag_a} : {(XLEN+1){1'b0}});
    sub_shift = work[2*XLEN-1:XLEN-1];
    sub_diff  = sub_shift - {1'b0, mag_b};
  end

  always_comb begin
    prod_s = (a_neg ^ b_neg) ? (~work + 1'b1) : work;
    quo_s  = (a_neg ^ b_neg) ? (~work[XLEN-1:0] + 1'b1) : work[XLEN-1:0];
    rem_s  = a_neg ? (~work[2*XLEN-1:XLEN] + 1'b1) : work[2*XLEN-1:XLEN];
    case (op_r)
      3'd0:             fix_val = prod_s[XLEN-1:0];
      3'd1, 3'd2, 3'd3: fix_val = prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5:       fix_val = b_zero ? {XLEN{1'b1}} : (ovf ? SMIN : quo_s);
      default:          fix_val = b_zero ? a_raw : (ovf ? {XLEN{1'b0}} : rem_s);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      op_r     <= '0;
      a_raw    <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      a_neg    <= 1'b0;
      b_neg    <= 1'b0;
      b_zero   <= 1'b0;
      ovf      <= 1'b0;
      work     <= '0;
      result_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            cnt    <= '0;
            op_r   <= bus.op;
            a_raw  <= bus.A;
            mag_a  <= abs_a;
            mag_b  <= abs_b;
            a_neg  <= sgn_a && bus.A[XLEN-1];
            b_neg  <= sgn_b && bus.B[XLEN-1];
            b_zero <= (bus.B == '0);
            ovf    <= ((bus.op == 3'd4) || (bus.op == 3'd6)) && (bus.A == SMIN) && (bus.B == '1);
            work   <= {{XLEN{1'b0}}, (bus.op[2] ? abs_a : abs_b)};
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (!op_r[2])
            work <= {add_sum, work[XLEN-1:1]};
          else if (sub_diff[XLEN])
            work <= {sub_shift[XLEN-1:0], work[XLEN-2:0], 1'b0};
          else
            work <= {sub_diff[XLEN-1:0], work[XLEN-2:0], 1'b1};
        end
        FIX:     result_r <= fix_val;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors, latency, backpressure and mid-op reset.
module tb_muldiv_unit;
  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  typedef struct {
    logic [31:0] exp;
    int          acc;
    string       name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cycle;
  int   checks;
  int   errors;
  logic prev_valid;
  exp_t sb[$];

  muldiv_unit_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  task automatic issue(input string name, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] e, input bit track);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      timeout({name, "_accept"});
      return;
    end
    bus.req_valid = 1'b1;
    bus.op        = o;
    bus.A         = a;
    bus.B         = b;
    @(posedge clk);
    #1;
    if (track) sb.push_back('{exp: e, acc: cycle, name: name});
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !bus.req_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || !bus.req_ready) timeout("drain");
  endtask

  // Monitor: every rising resp_valid pops one expectation and checks value and latency.
  initial begin
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.resp_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", bus.result, 32'hxxxx_xxxx);
        end else begin
          e = sb.pop_front();
          check(e.name, bus.result, e.exp);
          check({e.name, "_latency"}, 32'(cycle - e.acc), 32'd33);
        end
      end
      prev_valid = bus.resp_valid;
    end
  end

  initial begin
    int  n;
    bit  ok;
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.A          = '0;
    bus.B          = '0;
    bus.op         = '0;
    bus.resp_ready = 1'b1;
    #2;
    check("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    issue("mul_neg", MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
    issue("mulhu_max", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
    issue("mulh_min", MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1);
    issue("mulhsu_m1", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue("mulh_m1x7", MULH, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFF, 1'b1);
    issue("mul_shift", MUL, 32'h1234_5678, 32'h10, 32'h2345_6780, 1'b1);
    issue("mulhu_shift", MULHU, 32'h1234_5678, 32'h10, 32'h0000_0001, 1'b1);
    issue("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1);
    issue("rem_neg", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1);
    issue("div_negb", DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b1);
    issue("rem_negb", REM, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
    issue("divu", DIVU, 32'd100, 32'd7, 32'd14, 1'b1);
    issue("remu", REMU, 32'd100, 32'd7, 32'd2, 1'b1);
    issue("divu_big", DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);
    issue("remu_big", REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    issue("div_by0", DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1'b1);
    issue("divu_by0", DIVU, 32'd55, 32'd0, 32'hFFFF_FFFF, 1'b1);
    issue("remu_by0", REMU, 32'h1234, 32'd0, 32'h1234, 1'b1);
    issue("rem_by0", REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1'b1);
    issue("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    issue("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);
    drain();

    // Operands changing and a new request held high during CALC must not disturb the result.
    issue("divu_hold", DIVU, 32'd100, 32'd7, 32'd14, 1'b1);
    bus.req_valid = 1'b1;
    bus.op        = MUL;
    bus.A         = 32'd5;
    bus.B         = 32'd1;
    repeat (5) @(negedge clk);
    check("busy_req_ready", {31'b0, bus.req_ready}, 32'd0);
    check("busy_flag", {31'b0, bus.busy}, 32'd1);
    repeat (10) @(negedge clk);
    bus.req_valid = 1'b0;
    drain();

    bus.resp_ready = 1'b0;
    issue("mul_bp", MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
    n = 0;
    while (!bus.resp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.resp_valid) begin
      timeout("bp_wait");
    end else begin
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (!bus.resp_valid || bus.result !== 32'hFFFF_FFEB || bus.req_ready) ok = 1'b0;
      end
      check("bp_hold_stable", {31'b0, ok}, 32'd1);
      bus.resp_ready = 1'b1;
      @(negedge clk);
      check("bp_release_valid", {31'b0, bus.resp_valid}, 32'd0);
      check("bp_release_ready", {31'b0, bus.req_ready}, 32'd1);
    end
    drain();

    issue("div_abort", DIVU, 32'd1000, 32'd3, 32'd333, 1'b0);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("abort_result", bus.result, 32'd0);
    check("abort_req_ready", {31'b0, bus.req_ready}, 32'd1);
    check("abort_busy", {31'b0, bus.busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue("rem_after_rst", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1);
    drain();
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit that sits beside the single-cycle ALU in the execute stage.
- Accepts the same operand pair (A, B) plus an M-extension op select over a valid/ready request channel.
- Returns a 32-bit result over a valid/ready response channel after a fixed multi-cycle latency.
- The pipeline stalls on busy.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous, active-low reset.
req_valid  input  1  request present.
req_ready  output  1  unit can accept a request (high only in IDLE).
A  input  XLEN  operand rs1.
B  input  XLEN  operand rs2.
op  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
resp_valid  output  1  result valid.
resp_ready  input  1  consumer accepts result.
result  output  XLEN  operation result.
busy  output  1  high in CALC, FIX and DONE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, req_ready=1, resp_valid=0, busy=0, result=0, all internal registers cleared.
- Reset mid-operation aborts the operation; no response is produced.
- States:
  - IDLE -> CALC on req_valid && req_ready. A, B and op are latched at this edge; later input changes are ignored.
  - CALC runs XLEN cycles (iteration counter 0..XLEN-1), then -> FIX.
  - FIX is one cycle: sign correction and special cases; loads result and sets resp_valid. -> DONE.
  - DONE holds result and resp_valid stable until resp_ready, then -> IDLE and resp_valid drops.
- Latency: resp_valid rises XLEN+1 cycles after the acceptance edge (33 for XLEN=32).
  - Latency is identical for every op, including divide-by-zero and overflow.
- Throughput: req_ready is low in DONE, so at least one idle cycle occurs between response handshake and next acceptance.
- Multiply:
  - Shift-add on operand magnitudes into a 2*XLEN product; negate in FIX if the effective signs differ.
  - MUL: low XLEN bits. MULH: signed x signed, high bits. MULHSU: A signed, B unsigned, high bits. MULHU: unsigned x unsigned, high bits.
- Divide:
  - Restoring division on magnitudes (signed ops) or raw values (unsigned ops).
  - Quotient is negated if the signs of A and B differ; remainder takes the sign of A.
- Special cases, applied in FIX and overriding the above:
  - B==0: DIV/DIVU result = all ones; REM/REMU result = A.
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF): DIV result = 0x80000000; REM result = 0.
- A request asserted while busy is not accepted and must be held by the requester (req_ready=0).
- resp_ready asserted outside DONE has no effect.

Test Plan:
- MUL A=7, B=0xFFFFFFFD (-3) -> result 0xFFFFFFEB, resp_valid exactly 33 cycles after acceptance. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHSU A=0xFFFFFFFF, B=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV A=0xFFFFFFF9 (-7), B=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Divide by zero: DIV 0xFFFFFFF9/0 -> 0xFFFFFFFF. REMU 0x1234/0 -> 0x1234. Latency still 33.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same operands -> 0.
- Backpressure: hold resp_ready=0 for 10 cycles after resp_valid -> result and resp_valid stable, req_ready=0. Change A/B during CALC -> result unaffected.
- Reset mid-op: assert rst_n=0 at cycle 10 of CALC -> immediately resp_valid=0, result=0, req_ready=1. Next request completes correctly.
